// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic              dmem_req;
  logic              dmem_we;
  logic [AW-1:0]     dmem_addr;
  logic [DW-1:0]     dmem_wdata;
  logic [DW/8-1:0]   dmem_wstrb;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DW-1:0]     dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: req/gnt/rvalid data-bus handshake, load extension, store lane formatting.
// Optional WAIT-state bus timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             funct3,
  input  logic [31:0]            addr,
  input  logic [31:0]            store_data,
  load_store_unit_if.master      dmem,
  output logic [31:0]            mem_out,
  output logic                   lsu_stall,
  output logic                   lsu_done,
  output logic                   access_err,
  output logic                   bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        start_c;
  logic        err_c;
  logic [31:0] wdata_c;
  logic [3:0]  wstrb_c;
  logic [31:0] rshift_c;
  logic [31:0] load_c;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign bus_err = 1'b0;
`endif

  assign start_c   = (state == IDLE) && (mem_read || mem_write);
  assign lsu_stall = (state == REQ) || (state == WAIT) || (start_c && !err_c);

  // Alignment and encoding check; unsigned loads have no store counterpart.
  always_comb begin
    err_c = 1'b0;
    case (funct3)
      3'b000:  err_c = 1'b0;
      3'b001:  err_c = addr[0];
      3'b010:  err_c = |addr[1:0];
      3'b100:  err_c = mem_write;
      3'b101:  err_c = mem_write | addr[0];
      default: err_c = 1'b1;
    endcase
  end

  always_comb begin
    wdata_c = store_data;
    wstrb_c = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_c = {4{store_data[7:0]}};
        wstrb_c = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_c = {2{store_data[15:0]}};
        wstrb_c = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
  end

  // Word offset is zero for LW, so the shifted word doubles as the LW result.
  assign rshift_c = dmem.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_c = rshift_c;
    case (funct3_q)
      3'b000:  load_c = {{24{rshift_c[7]}}, rshift_c[7:0]};
      3'b100:  load_c = {24'h0, rshift_c[7:0]};
      3'b001:  load_c = {{16{rshift_c[15]}}, rshift_c[15:0]};
      3'b101:  load_c = {16'h0, rshift_c[15:0]};
      default: load_c = rshift_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      funct3_q        <= 3'b000;
      off_q           <= 2'b00;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_wdata <= 32'h0;
      dmem.dmem_wstrb <= 4'h0;
      mem_out         <= 32'h0;
      lsu_done        <= 1'b0;
      access_err      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err         <= 1'b0;
      tmo_cnt         <= '0;
`endif
    end else begin
      lsu_done   <= 1'b0;
      access_err <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_c) begin
            if (err_c) begin
              access_err <= 1'b1;
            end else begin
              state           <= REQ;
              funct3_q        <= funct3;
              off_q           <= addr[1:0];
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= mem_write;
              dmem.dmem_addr  <= {addr[31:2], 2'b00};
              dmem.dmem_wdata <= mem_write ? wdata_c : 32'h0;
              dmem.dmem_wstrb <= mem_write ? wstrb_c : 4'h0;
            end
          end
        end
        REQ: begin
          if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            if (dmem.dmem_we) begin
              state    <= DONE;
              lsu_done <= 1'b1;
            end else begin
              state <= WAIT;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
        end
        WAIT: begin
          if (dmem.dmem_rvalid) begin
            mem_out  <= load_c;
            state    <= DONE;
            lsu_done <= 1'b1;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, access errors, reset mid-access, timeout.
module tb_load_store_unit;
  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_out;
  logic        lsu_stall;
  logic        lsu_done;
  logic        access_err;
  logic        bus_err;
  logic [31:0] exp_mem;
  int          checks;
  int          failures;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .dmem       (bus),
    .mem_out    (mem_out),
    .lsu_stall  (lsu_stall),
    .lsu_done   (lsu_done),
    .access_err (access_err),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Load with one-cycle grant and one-cycle rvalid.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    mem_read = 1'b1; funct3 = f3; addr = a;
    @(negedge clk);
    mem_read = 1'b0;
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rd;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    chk32({tag, "_out"}, mem_out, exp);
    chk1({tag, "_done"}, lsu_done, 1'b1);
    @(negedge clk);
  endtask

  task automatic do_err(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = 32'h1234_5678;
    #1;
    chk1({tag, "_stall"}, lsu_stall, 1'b0);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    chk1({tag, "_err"}, access_err, 1'b1);
    chk1({tag, "_req"}, bus.dmem_req, 1'b0);
    chk32({tag, "_out"}, mem_out, exp_mem);
    @(negedge clk);
    chk1({tag, "_err_clr"}, access_err, 1'b0);
    chk1({tag, "_req2"}, bus.dmem_req, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk1("rst_req", bus.dmem_req, 1'b0);
    chk1("rst_we", bus.dmem_we, 1'b0);
    chk32("rst_addr", bus.dmem_addr, 32'h0);
    chk32("rst_wdata", bus.dmem_wdata, 32'h0);
    chk32("rst_wstrb", 32'(bus.dmem_wstrb), 32'h0);
    chk32("rst_mem_out", mem_out, 32'h0);
    chk1("rst_done", lsu_done, 1'b0);
    chk1("rst_aerr", access_err, 1'b0);
    chk1("rst_berr", bus_err, 1'b0);
    chk1("rst_stall", lsu_stall, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // LB at 0x1003: top byte 0x80 sign-extends
    mem_read = 1'b1; funct3 = 3'b000; addr = 32'h0000_1003;
    #1 chk1("lb_stall_c0", lsu_stall, 1'b1);
    @(negedge clk);
    mem_read = 1'b0;
    chk1("lb_req_c1", bus.dmem_req, 1'b1);
    chk32("lb_addr", bus.dmem_addr, 32'h0000_1000);
    chk1("lb_we", bus.dmem_we, 1'b0);
    chk32("lb_wstrb", 32'(bus.dmem_wstrb), 32'h0);
    chk1("lb_stall_c1", lsu_stall, 1'b1);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    chk1("lb_req_c2", bus.dmem_req, 1'b0);
    chk1("lb_stall_c2", lsu_stall, 1'b1);
    chk1("lb_done_c2", lsu_done, 1'b0);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h80FF_FF7F;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    chk32("lb_out", mem_out, 32'hFFFF_FF80);
    chk1("lb_done_c3", lsu_done, 1'b1);
    chk1("lb_stall_c3", lsu_stall, 1'b0);
    @(negedge clk);
    chk1("lb_done_c4", lsu_done, 1'b0);

    do_load("lhu", 3'b101, 32'h0000_2002, 32'hBEEF_1234, 32'h0000_BEEF);
    do_load("lh",  3'b001, 32'h0000_2002, 32'hBEEF_1234, 32'hFFFF_BEEF);
    do_load("lbu", 3'b100, 32'h0000_2001, 32'h0000_9A00, 32'h0000_009A);
    exp_mem = 32'hFFFF_BEEF;
    do_load("lw",  3'b010, 32'h0000_2000, 32'hCAFE_F00D, 32'hCAFE_F00D);
    exp_mem = 32'hCAFE_F00D;

    // SB at 0x3001 with grant delayed to the third REQ cycle
    mem_write = 1'b1; funct3 = 3'b000; addr = 32'h0000_3001; store_data = 32'h0000_00A5;
    #1 chk1("sb_stall_c0", lsu_stall, 1'b1);
    @(negedge clk);
    mem_write = 1'b0;
    chk1("sb_req_c1", bus.dmem_req, 1'b1);
    chk1("sb_we", bus.dmem_we, 1'b1);
    chk32("sb_addr", bus.dmem_addr, 32'h0000_3000);
    chk32("sb_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
    chk32("sb_wstrb", 32'(bus.dmem_wstrb), 32'h2);
    @(negedge clk);
    chk1("sb_req_c2", bus.dmem_req, 1'b1);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_7000;
    @(negedge clk);
    mem_read = 1'b0;
    chk1("sb_req_c3", bus.dmem_req, 1'b1);
    chk32("sb_addr_hold", bus.dmem_addr, 32'h0000_3000);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    chk1("sb_req_done", bus.dmem_req, 1'b0);
    chk1("sb_done", lsu_done, 1'b1);
    chk1("sb_stall_done", lsu_stall, 1'b0);
    chk32("sb_mem_out", mem_out, exp_mem);
    @(negedge clk);
    chk1("sb_done_clr", lsu_done, 1'b0);
    chk1("sb_no_req", bus.dmem_req, 1'b0);

    // SH upper half
    mem_write = 1'b1; funct3 = 3'b001; addr = 32'h0000_3002; store_data = 32'h0000_1234;
    @(negedge clk);
    mem_write = 1'b0;
    chk32("sh_wdata", bus.dmem_wdata, 32'h1234_1234);
    chk32("sh_wstrb", 32'(bus.dmem_wstrb), 32'hC);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    chk1("sh_done", lsu_done, 1'b1);
    @(negedge clk);

    // Stray rvalid in IDLE
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    chk32("stray_out", mem_out, exp_mem);
    chk1("stray_done", lsu_done, 1'b0);

    do_err("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_4002);
    do_err("sh_mis",  1'b0, 1'b1, 3'b001, 32'h0000_4001);
    do_err("f3_011",  1'b1, 1'b0, 3'b011, 32'h0000_4000);
    do_err("sbu_st",  1'b0, 1'b1, 3'b100, 32'h0000_4000);

    // Load granted but rvalid withheld
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000;
    @(negedge clk);
    mem_read = 1'b0;
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk1("to_wait_berr", bus_err, 1'b0);
      chk1("to_wait_stall", lsu_stall, 1'b1);
      @(negedge clk);
    end
    chk1("to_berr", bus_err, 1'b1);
    chk1("to_stall", lsu_stall, 1'b0);
    chk1("to_done", lsu_done, 1'b0);
    chk32("to_out", mem_out, exp_mem);
    @(negedge clk);
    chk1("to_berr_clr", bus_err, 1'b0);
`else
    repeat (6) @(negedge clk);
    chk1("nt_stall", lsu_stall, 1'b1);
    chk1("nt_berr", bus_err, 1'b0);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1122_3344;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    chk32("nt_out", mem_out, 32'h1122_3344);
    chk1("nt_done", lsu_done, 1'b1);
    @(negedge clk);
`endif

    // Reset while in WAIT; late rvalid must be ignored
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000;
    @(negedge clk);
    mem_read = 1'b0;
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("rw_req", bus.dmem_req, 1'b0);
    chk32("rw_out", mem_out, 32'h0);
    chk32("rw_addr", bus.dmem_addr, 32'h0);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    chk1("rw_done", lsu_done, 1'b0);
    chk32("rw_out2", mem_out, 32'h0);
    chk1("rw_stall", lsu_stall, 1'b0);
    @(negedge clk);
    chk1("rw_done2", lsu_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage between execute and writeback. It takes the ALU-computed address and store data, runs a request/grant/response handshake on the data-memory bus, and stalls the pipeline while the access is outstanding. For loads it byte-aligns and sign/zero-extends the returned word. It presents the result on mem_out, the memory-data input of the writeback select stage.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before a bus error (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
mem_read  in  1  execute requests a load
mem_write  in  1  execute requests a store; wins if mem_read is also set
funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
addr  in  32  byte address (ALU result)
store_data  in  32  rs2 value
dmem_req  out  1  bus request, held until granted
dmem_we  out  1  1 = write
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte enables
dmem_gnt  in  1  bus accepted request this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read word
mem_out  out  32  extended load result to writeback
lsu_stall  out  1  hold upstream pipeline
lsu_done  out  1  one-cycle completion pulse
access_err  out  1  one-cycle pulse: misaligned or unsupported funct3
bus_err  out  1  one-cycle timeout pulse; constant 0 without LSU_TIMEOUT_EN

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset: state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, mem_out=0, lsu_done=0, access_err=0, bus_err=0, timeout counter=0.
- Start condition: state is IDLE and (mem_read | mem_write). The block latches addr, funct3, store_data and the op type at that edge.
- Error check at start:
  - Half access with addr[0]=1 is an error.
  - Word access with addr[1:0]!=0 is an error.
  - funct3 outside the listed codes is an error. This includes 100/101 on a store.
  - On error: access_err pulses the next cycle, no bus request is made, mem_out is unchanged, state stays IDLE.
- REQ:
  - dmem_req=1, with dmem_addr, dmem_we, dmem_wdata and dmem_wstrb stable.
  - On dmem_gnt: a store goes to DONE, a load goes to WAIT.
- WAIT:
  - dmem_req=0.
  - dmem_rvalid is sampled only in WAIT. Any rvalid outside WAIT is ignored.
  - On rvalid, the extended data is registered into mem_out and state goes to DONE.
- DONE: lsu_done=1 for one cycle, then IDLE.
- mem_out holds its value until the next load completes. A store does not change it.
- lsu_stall is combinational:
  - 1 in REQ and WAIT.
  - 1 in IDLE while a valid (non-error) start is presented.
  - 0 in DONE, so the pipeline advances alongside lsu_done.
- Minimum latency:
  - Load: start c0, gnt c1, rvalid c2, lsu_done c3.
  - Store: start c0, gnt c1, lsu_done c2.
- Load extraction, with sh = addr[1:0]*8:
  - LB: sign-extend rdata[sh+7:sh].
  - LBU: zero-extend rdata[sh+7:sh].
  - LH: sign-extend rdata[sh+15:sh].
  - LHU: zero-extend rdata[sh+15:sh].
  - LW: rdata unchanged.
- Store formatting:
  - SB: wdata={4{data[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{data[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=data, wstrb=4'b1111.
  - For loads, wstrb=0 and dmem_we=0.
- Start requests presented in REQ, WAIT or DONE are ignored. Upstream is stalled or advancing in those states.
- Reset mid-transaction: at the reset edge the block returns to IDLE and drops dmem_req. A pending rvalid arriving after reset is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- When defined: a counter clears on entry to WAIT and increments each WAIT cycle without rvalid. At TIMEOUT_CYCLES, bus_err pulses for one cycle, mem_out is unchanged, lsu_done is not asserted, and state returns to IDLE.
- When undefined: there is no counter, bus_err is tied 0, and WAIT persists until rvalid.

Test Plan:
- LB at addr 0x1003, rdata 0x80FF_FF7F, gnt and rvalid each after 1 cycle -> mem_out=0xFFFF_FF80 registered on the WAIT→DONE edge, valid in DONE (c3 for min latency); lsu_done pulses in DONE; lsu_stall high c0-c2.
- LHU at addr 0x2002, rdata 0xBEEF_1234 -> mem_out=0x0000_BEEF. Same access as LH -> 0xFFFF_BEEF.
- SB at addr 0x3001, store_data 0x0000_00A5, gnt delayed 3 cycles -> dmem_req held 3 cycles, wdata=0xA5A5_A5A5, wstrb=4'b0010, mem_out unchanged, lsu_done 1 cycle after gnt.
- LW at addr 0x4002 -> access_err pulse, no dmem_req, lsu_stall 0. SH at addr 0x4001 -> same. funct3=011 -> same.
- Reset asserted in WAIT, then rvalid arrives next cycle -> state IDLE, all outputs at reset values, rvalid ignored, no lsu_done.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: load granted, no rvalid -> bus_err pulse after 4 WAIT cycles, lsu_stall drops, mem_out unchanged.
